// File: rtl/wishbone_rr_arbiter_pkg.sv
// rtl/wishbone_rr_arbiter_pkg.sv - shared types and round-robin search for the wishbone arbiter
package Wishbone_Arb_Pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int MAX_MASTERS     = 8;

  // First requester strictly after last_owner, wrapping modulo n; one-hot result.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                     input logic [2:0] last_owner,
                                                     input int n);
    logic [MAX_MASTERS-1:0] pick;
    logic [2:0]             idx;
    logic                   found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_MASTERS; k++) begin
      idx = 3'((int'(last_owner) + k) % n);
      if (k <= n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wishbone_rr_arbiter_picker.sv
// rtl/wishbone_rr_arbiter_picker.sv - combinational round-robin requester search
module wb_rr_picker
  import Wishbone_Arb_Pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [2:0]             last_owner,
  output logic [NUM_MASTERS-1:0] gnt
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_MASTERS-1:0] pick;
  logic                   unused_pick;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_MASTERS-1:0] = req;
  end

  assign pick        = rr_pick(req_ext, last_owner, NUM_MASTERS);
  assign gnt         = pick[NUM_MASTERS-1:0];
  assign unused_pick = ^pick;

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// rtl/wishbone_rr_arbiter.sv - per-cycle round-robin wishbone arbiter with stall watchdog
module wishbone_rr_arbiter
  import Wishbone_Arb_Pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int PORT_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic [NUM_MASTERS-1:0]         m_cyc_i,
  input  logic [NUM_MASTERS-1:0]         m_stb_i,
  input  logic [NUM_MASTERS-1:0]         m_we_i,
  input  logic [NUM_MASTERS*PORT_SIZE-1:0] m_adr_i,
  input  logic [NUM_MASTERS*PORT_SIZE-1:0] m_dat_i,
  output logic [PORT_SIZE-1:0]           m_dat_o,
  output logic [NUM_MASTERS-1:0]         m_ack_o,
  output logic [NUM_MASTERS-1:0]         m_err_o,
  output logic                           wb_cyc_o,
  output logic                           wb_stb_o,
  output logic                           wb_we_o,
  output logic [PORT_SIZE-1:0]           wb_adr_o,
  output logic [PORT_SIZE-1:0]           wb_dat_o,
  input  logic [PORT_SIZE-1:0]           wb_dat_i,
  input  logic                           wb_ack_i,
  output logic [NUM_MASTERS-1:0]         grant_o,
  output logic                           timeout_o
);

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_e             state, state_d;
  logic [NUM_MASTERS-1:0] grant, grant_d, pick;
  logic [2:0]             last_owner, last_owner_d, owner_idx;
  logic [15:0]            stall_cnt, stall_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   owned, owner_cyc, owner_stb, owner_we, stall, fire;
  logic [PORT_SIZE-1:0]   owner_adr, owner_dat;

  wb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req        (m_cyc_i),
    .last_owner (last_owner),
    .gnt        (pick)
  );

  // One-hot grant makes the owner mux a plain AND-OR.
  always_comb begin
    owner_adr = '0;
    owner_dat = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        owner_adr = owner_adr | m_adr_i[i*PORT_SIZE +: PORT_SIZE];
        owner_dat = owner_dat | m_dat_i[i*PORT_SIZE +: PORT_SIZE];
        owner_idx = 3'(i);
      end
    end
  end

  assign owner_cyc = |(m_cyc_i & grant);
  assign owner_stb = |(m_stb_i & grant);
  assign owner_we  = |(m_we_i & grant);
  assign owned     = (state == OWNED);
  assign stall     = wb_stb_o & ~wb_ack_i;
  assign fire      = (TIMEOUT_CYCLES > 0) && owned && owner_cyc && stall && (stall_cnt == STALL_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_owner <= 3'(NUM_MASTERS - 1);
      stall_cnt  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_owner <= last_owner_d;
      stall_cnt  <= stall_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_owner_d = last_owner;
    stall_cnt_d  = '0;
    timeout_d    = 1'b0;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          grant_d = pick;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!owner_cyc) begin
          last_owner_d = owner_idx;
          grant_d      = '0;
          state_d      = IDLE;
        end else if (fire) begin
          state_d   = ABORT;
          timeout_d = 1'b1;
        end else if (stall) begin
          stall_cnt_d = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          last_owner_d = owner_idx;
          grant_d      = '0;
          state_d      = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign wb_cyc_o  = owned & owner_cyc;
  assign wb_stb_o  = owned & owner_stb;
  assign wb_we_o   = owned & owner_we;
  assign wb_adr_o  = owned ? owner_adr : '0;
  assign wb_dat_o  = owned ? owner_dat : '0;
  assign m_dat_o   = wb_dat_i;
  assign m_ack_o   = grant & {NUM_MASTERS{wb_ack_i & owned}};
  assign m_err_o   = grant & {NUM_MASTERS{timeout_q}};
  assign grant_o   = grant;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// tb/tb_wishbone_rr_arbiter.sv - self-checking bench for the round-robin wishbone arbiter
module tb_wishbone_rr_arbiter;

  typedef struct {
    logic [1:0] gnt;
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [15:0] m_adr, m_dat;
  logic [7:0]  m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, grant_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, timeout_o;
  logic [7:0]  wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  wishbone_rr_arbiter #(.NUM_MASTERS(2), .PORT_SIZE(8), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  // Every acked slave beat must match the next expected beat, in order.
  always @(negedge clk) begin
    if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1 && wb_ack_i === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got gnt=%b we=%b adr=%h dat=%h, required no transfer",
                 grant_o, wb_we_o, wb_adr_o, wb_dat_o);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if ({grant_o, wb_we_o, wb_adr_o, wb_dat_o} !== {e.gnt, e.we, e.adr, e.dat}) begin
          miscompares++;
          $display("FAIL sb_beat: got gnt=%b we=%b adr=%h dat=%h, required gnt=%b we=%b adr=%h dat=%h",
                   grant_o, wb_we_o, wb_adr_o, wb_dat_o, e.gnt, e.we, e.adr, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past its time budget");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int idx, input logic cyc, input logic stb, input logic we,
                            input logic [7:0] adr, input logic [7:0] dat);
    m_cyc[idx] = cyc;
    m_stb[idx] = stb;
    m_we[idx]  = we;
    m_adr[idx*8 +: 8] = adr;
    m_dat[idx*8 +: 8] = dat;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    wb_ack_i = 1'b0; wb_dat_i = 8'h3C;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({grant_o, wb_cyc_o, wb_stb_o, m_ack_o, m_err_o, timeout_o} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required %b",
               {grant_o, wb_cyc_o, wb_stb_o, m_ack_o, m_err_o, timeout_o}, 9'b0);
    end
    vectors++;
    if (m_dat_o !== 8'h3C) begin
      miscompares++;
      $display("FAIL reset_dat_passthru: got %h, required %h", m_dat_o, 8'h3C);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    set_master(0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
    sb.push_back('{2'b01, 1'b0, 8'h10, 8'h00});
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL read_grant_latency: got %b, required %b", grant_o, 2'b00);
    end
    next_cycle();
    wb_ack_i = 1'b1; wb_dat_i = 8'hA5;
    @(negedge clk);
    vectors++;
    if ({grant_o, wb_cyc_o, m_ack_o} !== 5'b01_1_01) begin
      miscompares++;
      $display("FAIL read_grant_ack: got %b, required %b", {grant_o, wb_cyc_o, m_ack_o}, 5'b01101);
    end
    vectors++;
    if (m_dat_o !== 8'hA5) begin
      miscompares++;
      $display("FAIL read_data: got %h, required %h", m_dat_o, 8'hA5);
    end
    next_cycle();
    wb_ack_i = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    next_cycle();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL read_release: got %b, required %b", grant_o, 2'b00);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    int         e;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_master(0, 1'b1, 1'b1, 1'b0, 8'h30, 8'h00);
    set_master(1, 1'b1, 1'b1, 1'b0, 8'h31, 8'h00);
    for (int n = 0; n < 4; n++) begin
      e  = n % 2;
      eg = 2'b01 << e;
      sb.push_back('{eg, 1'b0, 8'h30 + 8'(e), 8'h00});
      next_cycle();
      wb_ack_i = 1'b1;
      @(negedge clk);
      vectors++;
      if ({grant_o, m_ack_o} !== {eg, eg}) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got grant=%b ack=%b, required %b", n, grant_o, m_ack_o, eg);
      end
      next_cycle();
      wb_ack_i = 1'b0;
      if (n == 3) begin
        m_cyc = '0; m_stb = '0;
      end else begin
        set_master(e, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      next_cycle();
      if (n < 2) set_master(e, 1'b1, 1'b1, 1'b0, 8'h30 + 8'(e), 8'h00);
      @(negedge clk);
      vectors++;
      if ({wb_cyc_o, grant_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL rr_dead_cycle[%0d]: got %b, required %b", n, {wb_cyc_o, grant_o}, 3'b000);
      end
    end
    next_cycle();
  endtask

  task automatic test_back_to_back_block();
    set_master(1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h01);
    sb.push_back('{2'b10, 1'b1, 8'h20, 8'h01});
    next_cycle();
    wb_ack_i = 1'b1;
    set_master(0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
    @(negedge clk);
    vectors++;
    if ({grant_o, m_ack_o} !== 4'b10_10) begin
      miscompares++;
      $display("FAIL block_grant: got %b, required %b", {grant_o, m_ack_o}, 4'b1010);
    end
    for (int b = 1; b < 3; b++) begin
      next_cycle();
      set_master(1, 1'b1, 1'b1, 1'b1, 8'h20 + 8'(b), 8'(b + 1));
      sb.push_back('{2'b10, 1'b1, 8'h20 + 8'(b), 8'(b + 1)});
      @(negedge clk);
      vectors++;
      if (m_ack_o !== 2'b10) begin
        miscompares++;
        $display("FAIL block_ack[%0d]: got %b, required %b", b, m_ack_o, 2'b10);
      end
    end
    next_cycle();
    wb_ack_i = 1'b0;
    set_master(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if ({grant_o, m_ack_o} !== 4'b10_00) begin
      miscompares++;
      $display("FAIL block_tail: got %b, required %b", {grant_o, m_ack_o}, 4'b1000);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({wb_cyc_o, grant_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL block_dead_cycle: got %b, required %b", {wb_cyc_o, grant_o}, 3'b000);
    end
    next_cycle();
    wb_ack_i = 1'b1;
    sb.push_back('{2'b01, 1'b0, 8'h40, 8'h00});
    @(negedge clk);
    vectors++;
    if ({grant_o, m_ack_o} !== 4'b01_01) begin
      miscompares++;
      $display("FAIL block_handover: got %b, required %b", {grant_o, m_ack_o}, 4'b0101);
    end
    next_cycle();
    wb_ack_i = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    next_cycle();
    next_cycle();
  endtask

  task automatic test_timeout();
    logic       exp_to, exp_cyc;
    logic [1:0] exp_err;
    set_master(0, 1'b1, 1'b1, 1'b0, 8'h60, 8'h00);
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (k == 5) wb_ack_i = 1'b1;
      exp_to  = (k == 4);
      exp_err = (k == 4) ? 2'b01 : 2'b00;
      exp_cyc = (k < 4);
      @(negedge clk);
      vectors++;
      if ({timeout_o, m_err_o, wb_cyc_o, m_ack_o} !== {exp_to, exp_err, exp_cyc, 2'b00}) begin
        miscompares++;
        $display("FAIL timeout_cycle[%0d]: got to=%b err=%b cyc=%b ack=%b, required to=%b err=%b cyc=%b ack=00",
                 k, timeout_o, m_err_o, wb_cyc_o, m_ack_o, exp_to, exp_err, exp_cyc);
      end
    end
    next_cycle();
    wb_ack_i = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL timeout_abort_hold: got %b, required %b", grant_o, 2'b01);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_release: got %b, required %b", grant_o, 2'b00);
    end
  endtask

  task automatic test_reset_mid_stall();
    next_cycle();
    set_master(1, 1'b1, 1'b1, 1'b0, 8'h70, 8'h00);
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({wb_cyc_o, grant_o} !== 3'b1_10) begin
      miscompares++;
      $display("FAIL rst_pre_owned: got %b, required %b", {wb_cyc_o, grant_o}, 3'b110);
    end
    next_cycle();
    rst = 1'b1;
    set_master(0, 1'b1, 1'b1, 1'b0, 8'h71, 8'h00);
    next_cycle();
    wb_ack_i = 1'b1;
    @(negedge clk);
    vectors++;
    if ({grant_o, wb_cyc_o, m_ack_o, m_err_o, timeout_o} !== 8'b0) begin
      miscompares++;
      $display("FAIL rst_mid_stall: got %b, required %b",
               {grant_o, wb_cyc_o, m_ack_o, m_err_o, timeout_o}, 8'b0);
    end
    next_cycle();
    rst = 1'b0;
    wb_ack_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({grant_o, wb_cyc_o, m_ack_o, m_err_o, timeout_o} !== 8'b0) begin
      miscompares++;
      $display("FAIL rst_hold: got %b, required %b",
               {grant_o, wb_cyc_o, m_ack_o, m_err_o, timeout_o}, 8'b0);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_first_tie: got %b, required %b", grant_o, 2'b01);
    end
    next_cycle();
    m_cyc = '0; m_stb = '0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_ack_vs_timeout();
    set_master(1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h77);
    sb.push_back('{2'b10, 1'b1, 8'h55, 8'h77});
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 3) wb_ack_i = 1'b1;
      @(negedge clk);
      vectors++;
      if ({timeout_o, wb_cyc_o, m_ack_o} !== {1'b0, 1'b1, (k == 3) ? 2'b10 : 2'b00}) begin
        miscompares++;
        $display("FAIL ack_race[%0d]: got to=%b cyc=%b ack=%b, required to=0 cyc=1 ack=%b",
                 k, timeout_o, wb_cyc_o, m_ack_o, (k == 3) ? 2'b10 : 2'b00);
      end
    end
    next_cycle();
    wb_ack_i = 1'b0;
    set_master(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if ({timeout_o, m_err_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL ack_race_no_abort: got %b, required %b", {timeout_o, m_err_o}, 3'b000);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL ack_race_release: got %b, required %b", grant_o, 2'b00);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back_block();
    test_timeout();
    test_reset_mid_stall();
    test_ack_vs_timeout();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending beats, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wishbone_rr_arbiter.md
Name: wishbone_rr_arbiter

Overview:
- Shares one 8-bit WISHBONE slave-side bus between NUM_MASTERS WISHBONE masters, for example the CPU-side bridge master and a DMA master.
- Grants ownership per bus cycle (wb_cyc) using round-robin priority.
- Muxes the owner's request signals to the slave bus and routes ack/data back to the owner only.
- A stall watchdog terminates hung cycles with an error pulse so no requester can deadlock the bus.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- PORT_SIZE, 8, width of address and data buses.
- TIMEOUT_CYCLES, 255, number of consecutive stb-without-ack cycles before forced abort; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  synchronous, active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cycle request.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_adr_i  in  NUM_MASTERS*PORT_SIZE  packed addresses; master i occupies [i*PORT_SIZE +: PORT_SIZE].
- m_dat_i  in  NUM_MASTERS*PORT_SIZE  packed write data, same packing.
- m_dat_o  out  PORT_SIZE  read data, broadcast to all masters (= wb_dat_i).
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master watchdog abort pulse.
- wb_cyc_o  out  1  to slave.
- wb_stb_o  out  1  to slave.
- wb_we_o  out  1  to slave.
- wb_adr_o  out  PORT_SIZE  to slave.
- wb_dat_o  out  PORT_SIZE  to slave.
- wb_dat_i  in  PORT_SIZE  from slave.
- wb_ack_i  in  1  from slave.
- grant_o  out  NUM_MASTERS  registered one-hot owner vector; 0 when no owner.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States are IDLE, OWNED and ABORT, with registers grant (one-hot), last_owner and stall_cnt.
- Reset values:
  - state=IDLE, grant=0, last_owner=NUM_MASTERS-1 (so master 0 wins the first tie), stall_cnt=0.
  - All outputs 0 except m_dat_o, which follows wb_dat_i.
- IDLE:
  - If any m_cyc_i is set, pick the first requester scanning from last_owner+1, wrapping modulo NUM_MASTERS.
  - Register it into grant and go to OWNED.
  - Latency: a request sampled at edge t gives grant_o and wb_cyc_o high after edge t, i.e. during the cycle following t.
- OWNED:
  - wb_cyc_o = m_cyc_i[owner] and wb_stb_o = m_stb_i[owner], both gated by state==OWNED (combinational from registered grant).
  - wb_we_o/wb_adr_o/wb_dat_o are the owner's fields; all zero when not OWNED.
  - m_ack_o[i] = wb_ack_i & grant[i] & (state==OWNED). Non-owners never see ack.
  - When m_cyc_i[owner] is sampled low: last_owner←owner, grant←0, go to IDLE.
  - Ownership is held across multiple stb phases while cyc stays high (block transfers).
- Dead cycle:
  - One IDLE cycle always separates consecutive owners, even when another master is already waiting. wb_cyc_o is low in that cycle.
  - The same master re-requesting after a release is re-granted only if no other master requests; round-robin then skips back to it.
- Watchdog (TIMEOUT_CYCLES>0):
  - stall_cnt increments each OWNED cycle with wb_stb_o & !wb_ack_i.
  - It clears on wb_ack_i, on !wb_stb_o, and on leaving OWNED.
  - When stall_cnt==TIMEOUT_CYCLES-1 and another stall cycle is sampled, go to ABORT. In that cycle m_err_o[owner]=1 and timeout_o=1 for exactly one cycle.
  - stall_cnt saturates; it never wraps.
- ABORT:
  - wb_cyc_o=wb_stb_o=0, no ack.
  - Stay until m_cyc_i[owner] is sampled low, then last_owner←owner, grant←0, IDLE.
  - A late wb_ack_i in ABORT is dropped.
- Simultaneous events:
  - wb_ack_i in the same cycle the counter would fire: the ack wins, no abort.
  - Owner drops cyc in the same cycle the slave acks: the ack is still routed, then release.
- Reset mid-cycle: state returns to IDLE at the reset edge, and wb_cyc_o drops in the following cycle. No ack or err is generated after reset.
- Masters' request signals are not registered; the slave sees the owner's signals with zero added latency once granted.

Decomposition:
- Package Wishbone_Arb_Pkg holds:
  - the arb_state_e enum (IDLE, OWNED, ABORT);
  - a function rr_pick(req, last_owner) returning a one-hot vector;
  - a localparam for the default timeout.
- One natural sub-module, wb_rr_picker: a combinational round-robin search, parameterized by NUM_MASTERS and instanced once. Everything else stays in the top module.

Test Plan:
- After reset, m_cyc_i=2'b01 with one read at adr 0x10 and slave dat 0xA5 → grant_o=01 one cycle after the request. m_ack_o=01 on the slave ack cycle, m_dat_o=0xA5. grant_o=00 after cyc drops.
- Both masters request at the same edge from reset → master 0 is granted first. After it releases: one dead cycle with wb_cyc_o=0, then grant_o=10. Repeat the pattern → the order alternates 0,1,0,1.
- Master 1 owns and does a 3-beat write 0x01/0x02/0x03 to adr 0x20..0x22 while master 0 requests throughout → the slave sees exactly 3 writes from master 1 with no interleaving. m_ack_o[0] stays 0 until master 0 is granted.
- TIMEOUT_CYCLES=4, slave never acks → m_err_o[owner] and timeout_o pulse high exactly once, after the 4th stall cycle. wb_cyc_o drops that cycle. An injected late wb_ack_i is not routed. The arbiter returns to IDLE after the owner drops cyc.
- Assert wb_rst_i during an OWNED cycle mid-stall → grant_o=0 and wb_cyc_o=0 from the next cycle. No m_ack_o or m_err_o pulses. The first post-reset tie goes to master 0.
- wb_ack_i arrives on the same cycle stall_cnt reaches TIMEOUT_CYCLES-1 → normal ack to the owner, no timeout_o pulse.
